// File: rtl/mem_dump_tx.sv
// mem_dump_tx
// Serial read-out engine for the data memory. On a start request it walks a
// range of 32-bit words, fetching one word per FETCH cycle, and sends each
// word as four 8N1 frames (least-significant byte first, LSB-first bits).
//
// Ports:
//   clock         system clock, rising-edge active
//   reset         asynchronous active-low reset
//   start         one-cycle dump request, honoured only while idle
//   base_address  first word address, latched on accepted start
//   word_count    number of words, latched on accepted start (0 = no-op dump)
//   memAddress    address to the data memory, holds its value outside FETCH
//   memRead       memory output enable, high only during FETCH
//   memData       combinational memory read data, valid while memRead is high
//   tx            serial line, idles high
//   busy          high from start acceptance until the dump completes
//   done          one-cycle completion pulse
module mem_dump_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int ADDR_WIDTH   = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_address,
  input  logic [15:0]           word_count,
  output logic [ADDR_WIDTH-1:0] memAddress,
  output logic                  memRead,
  input  logic [31:0]           memData,
  output logic                  tx,
  output logic                  busy,
  output logic                  done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_START_BIT,
    S_DATA_BITS,
    S_STOP_BIT,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [15:0]             remain_q, remain_d;
  logic [31:0]             shift_q, shift_d;
  logic [1:0]              byte_idx_q, byte_idx_d;
  logic [2:0]              bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  // State register. Asynchronous reset drops the FSM to IDLE, which forces
  // tx high immediately through the output logic below.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      remain_q   <= '0;
      shift_q    <= '0;
      byte_idx_q <= '0;
      bit_idx_q  <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      shift_q    <= shift_d;
      byte_idx_q <= byte_idx_d;
      bit_idx_q  <= bit_idx_d;
      cnt_q      <= cnt_d;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    remain_d   = remain_q;
    shift_d    = shift_q;
    byte_idx_d = byte_idx_q;
    bit_idx_d  = bit_idx_q;
    cnt_d      = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (word_count != 16'd0) begin
            addr_d   = base_address;
            remain_d = word_count;
            state_d  = S_FETCH;
          end else begin
            // Nothing to send: report completion without touching memory.
            state_d = S_DONE;
          end
        end
      end

      S_FETCH: begin
        shift_d    = memData;
        byte_idx_d = 2'd0;
        cnt_d      = CNT_LOAD;
        state_d    = S_START_BIT;
      end

      S_START_BIT: begin
        if (cnt_q == '0) begin
          cnt_d     = CNT_LOAD;
          bit_idx_d = 3'd0;
          state_d   = S_DATA_BITS;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_DATA_BITS: begin
        if (cnt_q == '0) begin
          cnt_d = CNT_LOAD;
          // Shifting the whole word right streams bytes LSB-first in order,
          // so tx only ever needs shift_q[0].
          shift_d = {1'b0, shift_q[31:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP_BIT;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_STOP_BIT: begin
        if (cnt_q == '0) begin
          if (byte_idx_q != 2'd3) begin
            byte_idx_d = byte_idx_q + 2'd1;
            cnt_d      = CNT_LOAD;
            state_d    = S_START_BIT;
          end else if (remain_q > 16'd1) begin
            remain_d = remain_q - 16'd1;
            addr_d   = addr_q + ADDR_WIDTH'(1);  // wraps modulo 2^ADDR_WIDTH
            state_d  = S_FETCH;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from registered state. addr_q only changes on entry to
  // FETCH, so memAddress naturally holds the last fetched address elsewhere.
  always_comb begin
    memAddress = addr_q;
    memRead    = 1'b0;
    tx         = 1'b1;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      S_FETCH: begin
        memRead = 1'b1;
        busy    = 1'b1;
      end
      S_START_BIT: begin
        tx   = 1'b0;
        busy = 1'b1;
      end
      S_DATA_BITS: begin
        tx   = shift_q[0];
        busy = 1'b1;
      end
      S_STOP_BIT: begin
        busy = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_dump_tx.sv
// Testbench for mem_dump_tx with CLKS_PER_BIT=4. Expected serial traces, fetch
// pulses and done timing come from a per-cycle reference built out of the
// frame rules (fetch cycle + four 10-bit frames per word).
module tb_mem_dump_tx;

  localparam int C = 4;
  localparam int P = 1 + 40 * C;   // cycles per word

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_address = '0;
  logic [15:0] word_count = '0;
  logic [31:0] mem_address;
  logic        mem_read;
  logic [31:0] mem_data;
  logic        tx;
  logic        busy;
  logic        done;

  logic [31:0] mem [16];
  logic [31:0] last_addr = '0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] base;
    int          count;
    int          mid_k;     // 0 = no extra start; else start sampled at edge E0+mid_k
    int          exp_done;  // cycle offset (after E0) in which done is high
  } vec_t;

  vec_t vecs [6];

  assign mem_data = mem[mem_address[3:0]];

  always #5 clock = ~clock;

  mem_dump_tx #(
    .CLKS_PER_BIT(C),
    .ADDR_WIDTH  (32)
  ) u_dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .base_address(base_address),
    .word_count  (word_count),
    .memAddress  (mem_address),
    .memRead     (mem_read),
    .memData     (mem_data),
    .tx          (tx),
    .busy        (busy),
    .done        (done)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", name, got, exp);
    end
  endtask

  task automatic run_dump(input logic [31:0] base, input int count, input int mid_k,
                          input int exp_done);
    logic        tx_s[$];
    logic        rd_s[$];
    logic        busy_s[$];
    logic        done_s[$];
    logic [31:0] addr_s[$];
    logic        exp_tx[$];
    logic [31:0] a;
    logic [31:0] w;
    logic [31:0] exp_addr;
    int          len;
    int          bad;
    int          first_done;
    int          n_done;
    int          widx;

    // Reference serial trace: fetch cycle at idle level, then 4 frames.
    for (int i = 0; i < count; i++) begin
      a = base + 32'(i);
      w = mem[a[3:0]];
      exp_tx.push_back(1'b1);
      for (int b = 0; b < 4; b++) begin
        for (int c = 0; c < C; c++) exp_tx.push_back(1'b0);
        for (int j = 0; j < 8; j++)
          for (int c = 0; c < C; c++) exp_tx.push_back(w[8*b+j]);
        for (int c = 0; c < C; c++) exp_tx.push_back(1'b1);
      end
    end
    exp_tx.push_back(1'b1);
    exp_tx.push_back(1'b1);
    len = count * P + 2;

    @(negedge clock);
    start = 1'b1;
    base_address = base;
    word_count = 16'(count);
    @(posedge clock);  // E0
    #1;
    start = 1'b0;
    for (int k = 0; k < len; k++) begin
      tx_s.push_back(tx);
      rd_s.push_back(mem_read);
      busy_s.push_back(busy);
      done_s.push_back(done);
      addr_s.push_back(mem_address);
      if (k == mid_k - 1) begin
        start = 1'b1;
        base_address = ~base;
        word_count = 16'd5;
      end else begin
        start = 1'b0;
        base_address = base;
        word_count = 16'(count);
      end
      @(posedge clock);
      #1;
    end
    start = 1'b0;

    // Serial line, one comparison per word plus the idle tail.
    for (int i = 0; i <= count; i++) begin
      bad = -1;
      for (int k = i * P; k < ((i == count) ? len : (i + 1) * P); k++)
        if (bad < 0 && tx_s[k] !== exp_tx[k]) bad = k;
      checks++;
      if (bad >= 0) begin
        errors++;
        $display("FAIL tx word %0d cycle %0d got=%b exp=%b", i, bad, tx_s[bad], exp_tx[bad]);
      end
    end

    // Fetch strobe, address and busy over the whole window.
    bad = -1;
    for (int k = 0; k < len; k++)
      if (bad < 0 && rd_s[k] !== ((k < count * P) && (k % P == 0))) bad = k;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL memread cycle %0d got=%b exp=%b", bad, rd_s[bad], ~rd_s[bad]);
    end

    bad = -1;
    for (int k = 0; k < len; k++) begin
      widx = (k / P < count - 1) ? k / P : count - 1;
      exp_addr = (count == 0) ? last_addr : base + 32'(widx);
      if (bad < 0 && addr_s[k] !== exp_addr) begin
        bad = k;
        $display("FAIL memaddr cycle %0d got=0x%08h exp=0x%08h", k, addr_s[k], exp_addr);
      end
    end
    checks++;
    if (bad >= 0) errors++;

    bad = -1;
    for (int k = 0; k < len; k++)
      if (bad < 0 && busy_s[k] !== (k < count * P)) bad = k;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL busy cycle %0d got=%b exp=%b", bad, busy_s[bad], ~busy_s[bad]);
    end

    first_done = -1;
    n_done = 0;
    for (int k = 0; k < len; k++) begin
      if (done_s[k] === 1'b1) begin
        n_done++;
        if (first_done < 0) first_done = k;
      end
    end
    check("done_cycle", 32'(first_done), 32'(exp_done));
    check("done_pulses", 32'(n_done), 32'd1);

    if (count > 0) last_addr = base + 32'(count - 1);
    $display("dump base=0x%08h count=%0d mid_start=%0d done_at=%0d", base, count, mid_k,
             first_done);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[0]  = 32'hA5A5A5A5;
    mem[1]  = 32'h00000001;
    mem[2]  = 32'hFFFFFFFF;
    mem[5]  = 32'h12345678;
    mem[7]  = 32'h00000055;
    mem[8]  = 32'h00000000;
    mem[15] = 32'hDEADBEEF;

    vecs[0] = '{32'd5,        1, 0,  161};   // single word
    vecs[1] = '{32'd0,        3, 0,  483};   // multi-word
    vecs[2] = '{32'hFFFFFFFF, 2, 0,  322};   // address wrap
    vecs[3] = '{32'd9,        0, 0,  0};     // zero count
    vecs[4] = '{32'd5,        1, 40, 161};   // start while busy
    vecs[5] = '{32'd7,        1, 0,  161};   // 0x55 bit timing

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_memread", 32'(mem_read), 32'd0);
    check("reset_memaddr", mem_address, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // Reset in the middle of DATA_BITS of an all-zero word
    @(negedge clock);
    start = 1'b1;
    base_address = 32'd8;
    word_count = 16'd1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (C + 3) @(posedge clock);
    #1;
    check("midrst_pre_tx", 32'(tx), 32'd0);
    check("midrst_pre_busy", 32'(busy), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_tx", 32'(tx), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_memread", 32'(mem_read), 32'd0);
    check("midrst_memaddr", mem_address, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      check("midrst_hold_done", 32'(done), 32'd0);
      check("midrst_hold_tx", 32'(tx), 32'd1);
    end
    @(negedge clock);
    reset = 1'b1;
    last_addr = '0;

    // Directed table
    for (int v = 0; v < 6; v++)
      run_dump(vecs[v].base, vecs[v].count, vecs[v].mid_k, vecs[v].exp_done);

    // Randomized dumps
    for (int r = 0; r < 6; r++) begin
      logic [31:0] rb;
      int          rc;
      int          rm;
      for (int i = 0; i < 16; i++) mem[i] = $urandom;
      rb = $urandom;
      if (r == 0) rb = 32'hFFFFFFFE;
      rc = int'($urandom_range(0, 3));
      rm = 0;
      if (rc > 0 && $urandom_range(0, 1) == 1) rm = int'($urandom_range(1, rc * P));
      run_dump(rb, rc, rm, rc * P);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
